// File: rtl/mmu_seq_ctrl.sv
// Sequencer for the systolic matrix-multiply array: weight tile load, input
// streaming and result write-back, with all buffer addressing generated here.
module mmu_seq_ctrl #(
    parameter int ARRAY_N  = 16,
    parameter int ADDR_W   = 8,
    parameter int FILL_LAT = 2*ARRAY_N-1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_rows,
    input  logic [ADDR_W-1:0] wbase,
    input  logic [ADDR_W-1:0] dbase,
    input  logic [ADDR_W-1:0] obase,
    input  logic              stall,
    output logic              wbuf_rd_en,
    output logic [ADDR_W-1:0] wbuf_addr,
    output logic              wwrite,
    output logic              dbuf_rd_en,
    output logic [ADDR_W-1:0] dbuf_addr,
    output logic              active,
    output logic              obuf_wr_en,
    output logic [ADDR_W-1:0] obuf_addr,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] N_C      = CNT_W'(ARRAY_N);
    localparam logic [CNT_W-1:0] WL_STEPS = CNT_W'(ARRAY_N + 1);
    localparam logic [CNT_W-1:0] FILL_C   = CNT_W'(FILL_LAT);

    typedef enum logic [1:0] {IDLE, WLOAD, COMPUTE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rows_q, rows_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d, dbase_q, dbase_d, obase_q, obase_d;
    logic              wbuf_rd_en_q, wbuf_rd_en_d, wwrite_q, wwrite_d;
    logic              dbuf_rd_en_q, dbuf_rd_en_d, active_q, active_d;
    logic              obuf_wr_en_q, obuf_wr_en_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d, dbuf_addr_q, dbuf_addr_d;
    logic [ADDR_W-1:0] obuf_addr_q, obuf_addr_d;

    logic              doStep;
    logic [CNT_W-1:0]  stepT, lastStep, outIdx;

    // cnt_q is the index of the next schedule step to emit; the registered
    // outputs always show the step chosen at the previous edge.
    assign lastStep = FILL_C + {1'b0, rows_q};
    assign outIdx   = stepT - FILL_C - ONE;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rows_d       = rows_q;
        wbase_d      = wbase_q;
        dbase_d      = dbase_q;
        obase_d      = obase_q;
        wbuf_rd_en_d = 1'b0;
        wwrite_d     = 1'b0;
        dbuf_rd_en_d = 1'b0;
        active_d     = 1'b0;
        obuf_wr_en_d = 1'b0;
        wbuf_addr_d  = wbuf_addr_q;
        dbuf_addr_d  = dbuf_addr_q;
        obuf_addr_d  = obuf_addr_q;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        doStep       = 1'b0;
        stepT        = '0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    rows_d       = num_rows;
                    wbase_d      = wbase;
                    dbase_d      = dbase;
                    obase_d      = obase;
                    state_d      = WLOAD;
                    busy_d       = 1'b1;
                    wbuf_rd_en_d = 1'b1;
                    wbuf_addr_d  = wbase;
                    cnt_d        = ONE;
                end
            end
            WLOAD: begin
                if (!stall) begin
                    if (cnt_q == WL_STEPS) begin
                        if (rows_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = COMPUTE;
                            doStep  = 1'b1;
                            cnt_d   = ONE;
                        end
                    end else begin
                        // Each weight read is shifted into the array one cycle later.
                        if (cnt_q < N_C) begin
                            wbuf_rd_en_d = 1'b1;
                            wbuf_addr_d  = wbase_q + cnt_q[ADDR_W-1:0];
                        end
                        wwrite_d = 1'b1;
                        cnt_d    = cnt_q + ONE;
                    end
                end
            end
            COMPUTE: begin
                if (!stall) begin
                    if (cnt_q > lastStep) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        doStep = 1'b1;
                        stepT  = cnt_q;
                        cnt_d  = cnt_q + ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (doStep) begin
            dbuf_rd_en_d = (stepT < {1'b0, rows_q});
            if (dbuf_rd_en_d) dbuf_addr_d = dbase_q + stepT[ADDR_W-1:0];
            active_d     = (stepT != '0);
            obuf_wr_en_d = (stepT > FILL_C);
            if (obuf_wr_en_d) obuf_addr_d = obase_q + outIdx[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rows_q       <= '0;
            wbase_q      <= '0;
            dbase_q      <= '0;
            obase_q      <= '0;
            wbuf_rd_en_q <= 1'b0;
            wwrite_q     <= 1'b0;
            dbuf_rd_en_q <= 1'b0;
            active_q     <= 1'b0;
            obuf_wr_en_q <= 1'b0;
            wbuf_addr_q  <= '0;
            dbuf_addr_q  <= '0;
            obuf_addr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rows_q       <= rows_d;
            wbase_q      <= wbase_d;
            dbase_q      <= dbase_d;
            obase_q      <= obase_d;
            wbuf_rd_en_q <= wbuf_rd_en_d;
            wwrite_q     <= wwrite_d;
            dbuf_rd_en_q <= dbuf_rd_en_d;
            active_q     <= active_d;
            obuf_wr_en_q <= obuf_wr_en_d;
            wbuf_addr_q  <= wbuf_addr_d;
            dbuf_addr_q  <= dbuf_addr_d;
            obuf_addr_q  <= obuf_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign wbuf_rd_en = wbuf_rd_en_q;
    assign wbuf_addr  = wbuf_addr_q;
    assign wwrite     = wwrite_q;
    assign dbuf_rd_en = dbuf_rd_en_q;
    assign dbuf_addr  = dbuf_addr_q;
    assign active     = active_q;
    assign obuf_wr_en = obuf_wr_en_q;
    assign obuf_addr  = obuf_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Self-checking bench for mmu_seq_ctrl: a slot-based schedule model predicts
// every output per cycle, with stall cycles inserted as blank busy cycles.
module tb_mmu_seq_ctrl;

    localparam int N  = 4;
    localparam int F  = 2*N-1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] num_rows = '0, wbase = '0, dbase = '0, obase = '0;
    logic       wbuf_rd_en, wwrite, dbuf_rd_en, active, obuf_wr_en, busy, done;
    logic [7:0] wbuf_addr, dbuf_addr, obuf_addr;
    logic [6:0] strobes;
    logic [30:0] allOut;

    int nCompared = 0;
    int nMismatched = 0;
    bit stallPlan[0:4095];

    typedef struct packed {
        logic       wrd;
        logic       ww;
        logic       drd;
        logic       act;
        logic       owr;
        logic       busy;
        logic       done;
        logic [7:0] waddr;
        logic [7:0] daddr;
        logic [7:0] oaddr;
    } exp_t;

    mmu_seq_ctrl #(.ARRAY_N(N), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .wbase(wbase), .dbase(dbase), .obase(obase), .stall(stall),
        .wbuf_rd_en(wbuf_rd_en), .wbuf_addr(wbuf_addr), .wwrite(wwrite),
        .dbuf_rd_en(dbuf_rd_en), .dbuf_addr(dbuf_addr), .active(active),
        .obuf_wr_en(obuf_wr_en), .obuf_addr(obuf_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign strobes = {wbuf_rd_en, wwrite, dbuf_rd_en, active, obuf_wr_en, busy, done};
    assign allOut  = {strobes, wbuf_addr, dbuf_addr, obuf_addr};

    // Slot s is the nominal cycle number counted from the start command.
    function automatic int doneSlot(int r);
        return (r == 0) ? N+2 : N+3+F+r;
    endfunction

    function automatic exp_t slotExp(int s, int r, int wb, int db, int ob);
        exp_t e = '0;
        int dn = doneSlot(r);
        e.busy = (s >= 1 && s <= dn);
        e.done = (s == dn);
        if (s >= 1 && s <= N) begin e.wrd = 1'b1; e.waddr = 8'(wb + s - 1); end
        e.ww = (s >= 2 && s <= N+1);
        if (r > 0) begin
            if (s >= N+2 && s <= N+1+r) begin e.drd = 1'b1; e.daddr = 8'(db + s - N - 2); end
            e.act = (s >= N+3 && s <= N+2+F+r);
            if (s >= N+3+F && s <= N+2+F+r) begin e.owr = 1'b1; e.oaddr = 8'(ob + s - N - 3 - F); end
        end
        return e;
    endfunction

    // Issues one start at cycle 0 and checks every cycle until two idle cycles
    // after done; stallPlan[c] is the stall value seen by the edge opening cycle c.
    task automatic runSchedule(input int r, input int wb, input int db, input int ob,
                               input int secondStart, input int abortAt, input string tag);
        exp_t e;
        int slot = 1;
        int dn = doneSlot(r);
        @(negedge clk);
        num_rows = 8'(r); wbase = 8'(wb); dbase = 8'(db); obase = 8'(ob);
        start = 1'b1;
        stall = stallPlan[1];
        for (int c = 1; c < 4000; c++) begin
            @(negedge clk);
            start = 1'b0;
            num_rows = 8'($urandom); wbase = 8'($urandom); dbase = 8'($urandom); obase = 8'($urandom);
            if (c == 1 || !stallPlan[c] || slot > dn) begin
                e = slotExp(slot, r, wb, db, ob);
                slot++;
            end else begin
                e = '0;
                e.busy = 1'b1;
            end
            nCompared++;
            if (strobes !== {e.wrd, e.ww, e.drd, e.act, e.owr, e.busy, e.done}) begin
                nMismatched++;
                $display("[TB] FAIL %s strobes cycle %0d: got %b want %b", tag, c, strobes,
                         {e.wrd, e.ww, e.drd, e.act, e.owr, e.busy, e.done});
            end
            if (e.wrd) begin
                nCompared++;
                if (wbuf_addr !== e.waddr) begin
                    nMismatched++;
                    $display("[TB] FAIL %s wbuf_addr cycle %0d: got %h want %h", tag, c, wbuf_addr, e.waddr);
                end
            end
            if (e.drd) begin
                nCompared++;
                if (dbuf_addr !== e.daddr) begin
                    nMismatched++;
                    $display("[TB] FAIL %s dbuf_addr cycle %0d: got %h want %h", tag, c, dbuf_addr, e.daddr);
                end
            end
            if (e.owr) begin
                nCompared++;
                if (obuf_addr !== e.oaddr) begin
                    nMismatched++;
                    $display("[TB] FAIL %s obuf_addr cycle %0d: got %h want %h", tag, c, obuf_addr, e.oaddr);
                end
            end
            if (c == abortAt) begin
                rst_n = 1'b0;
                stall = 1'b0;
                #1;
                nCompared++;
                if (allOut !== '0) begin
                    nMismatched++;
                    $display("[TB] FAIL %s abort outputs: got %h want 0", tag, allOut);
                end
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    nCompared++;
                    if (allOut !== '0) begin
                        nMismatched++;
                        $display("[TB] FAIL %s held-reset outputs: got %h want 0", tag, allOut);
                    end
                end
                rst_n = 1'b1;
                stallPlan = '{default: 1'b0};
                return;
            end
            if (slot > dn + 2) break;
            start = (c == secondStart);
            stall = stallPlan[c+1];
        end
        start = 1'b0;
        stall = 1'b0;
        stallPlan = '{default: 1'b0};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nCompared++;
            if (allOut !== '0) begin
                nMismatched++;
                $display("[TB] FAIL reset outputs: got %h want 0", allOut);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nCompared++;
            if (allOut !== '0) begin
                nMismatched++;
                $display("[TB] FAIL idle outputs cycle %0d: got %h want 0", k, allOut);
            end
        end
    endtask

    task automatic test_nominal();
        runSchedule(3, 'h10, 'h20, 'h40, -1, -1, "nominal");
    endtask

    task automatic test_stall();
        stallPlan[7] = 1'b1;
        stallPlan[8] = 1'b1;
        runSchedule(3, 'h10, 'h20, 'h40, -1, -1, "stall");
    endtask

    task automatic test_zero_rows();
        runSchedule(0, 'h33, 'h20, 'h40, -1, -1, "zero_rows");
    endtask

    task automatic test_wrap_ignore();
        runSchedule(3, 'hFD, 'hFE, 'hFF, 9, -1, "wrap_ignore");
    endtask

    task automatic test_abort();
        runSchedule(3, 'h10, 'h20, 'h40, -1, 10, "abort");
        runSchedule(3, 'h10, 'h20, 'h40, -1, -1, "after_abort");
    endtask

    task automatic test_back_to_back();
        runSchedule(2, 'h01, 'h02, 'h03, doneSlot(2), -1, "start_in_done");
        runSchedule(1, 'h80, 'h90, 'hA0, -1, -1, "back_to_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int r = (i == 9) ? 255 : int'($urandom_range(0, 12));
            int dn = doneSlot(r);
            for (int c = 1; c <= dn + 3; c++) stallPlan[c] = ($urandom_range(0, 3) == 0);
            runSchedule(r, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), int'($urandom_range(1, dn)), -1, "random");
        end
    endtask

    initial begin
        stallPlan = '{default: 1'b0};
        test_reset();
        test_nominal();
        test_stall();
        test_zero_rows();
        test_wrap_ignore();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
